// File: rtl/presc_multi.sv
// presc_multi: parametrised multi-channel prescaler.
// Each of CH channels counts enabled ticks from 0 up to a latched terminal
// value D. It emits a one-cycle strobe on wrap, so the period is D+1 ticks.
// A channel runs either continuously (mode=0) or as a one-shot (mode=1,
// armed by start).
//
// Optional feature: define PRESC_CASCADE_EN to chain the channels. Channel i
// (i>=1) then ticks only on channel i-1's strobe.
//
// Ports:
//   clk    - system clock, posedge
//   rst    - synchronous active-low reset
//   en     - global tick enable; 0 pauses every channel
//   div_i  - per-channel terminal value, slice [i*WIDTH +: WIDTH]
//   mode   - per-channel: 0 continuous, 1 one-shot
//   start  - per-channel one-shot trigger
//   Qount  - per-channel current count (registered)
//   strb   - per-channel terminal strobe (registered)
//   busy   - per-channel RUN indicator (registered)
module presc_multi #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CH    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [CH*WIDTH-1:0]   div_i,
   input  logic [CH-1:0]         mode,
   input  logic [CH-1:0]         start,
   output logic [CH*WIDTH-1:0]   Qount,
   output logic [CH-1:0]         strb,
   output logic [CH-1:0]         busy
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] div_q, div_d;
      state_e           state_q, state_d;
      logic             strb_q, strb_d;
      logic             busy_q, busy_d;
      logic             casc_c;
      logic             tick_c;

      // Cascade gate: the downstream channel advances only on the upstream strobe
`ifdef PRESC_CASCADE_EN
      if (i > 0) begin : g_casc
         assign casc_c = strb[i-1];
      end else begin : g_head
         assign casc_c = 1'b1;
      end
`else
      assign casc_c = 1'b1;
`endif

      assign tick_c = en & (state_q == S_RUN) & casc_c;

      // Next-state: entry edge does not count; D is reloaded only on wrap
      always_comb begin
         cnt_d   = cnt_q;
         div_d   = div_q;
         state_d = state_q;
         strb_d  = 1'b0;
         if (state_q == S_IDLE) begin
            if (en && (!mode[i] || start[i])) begin
               state_d = S_RUN;
            end
         end else if (tick_c) begin
            if (cnt_q == div_q) begin
               cnt_d  = '0;
               strb_d = 1'b1;
               div_d  = div_i[i*WIDTH +: WIDTH];
               if (mode[i]) begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end
         busy_d = (state_d == S_RUN);
      end

      // State registers; reset also samples the divide value
      always_ff @(posedge clk) begin
         if (!rst) begin
            cnt_q   <= '0;
            div_q   <= div_i[i*WIDTH +: WIDTH];
            state_q <= S_IDLE;
            strb_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            state_q <= state_d;
            strb_q  <= strb_d;
            busy_q  <= busy_d;
         end
      end

      assign Qount[i*WIDTH +: WIDTH] = cnt_q;
      assign strb[i]                 = strb_q;
      assign busy[i]                 = busy_q;
   end

endmodule

// File: tb/tb_presc_multi.sv
// Directed bench for presc_multi (WIDTH=4, CH=2).
module tb_presc_multi;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned CH    = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic [CH*WIDTH-1:0] div_i;
   logic [CH-1:0]       mode;
   logic [CH-1:0]       start;
   logic [CH*WIDTH-1:0] Qount;
   logic [CH-1:0]       strb;
   logic [CH-1:0]       busy;

   int checks = 0;
   int errors = 0;

   int exp_c0 [12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
   int exp_s0 [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

   presc_multi #(.WIDTH(WIDTH), .CH(CH)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .div_i (div_i),
      .mode  (mode),
      .start (start),
      .Qount (Qount),
      .strb  (strb),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst   = 1'b0;
      en    = 1'b1;
      mode  = 2'b00;
      start = 2'b00;
      div_i = {4'd15, 4'd4};

      // Reset dominates en/start
      for (int k = 0; k < 5; k++) begin
         start = 2'($urandom);
         tick();
         chk("rst_qount", 32'(Qount), 32'd0);
         chk("rst_strb",  32'(strb),  32'd0);
         chk("rst_busy",  32'(busy),  32'd0);
      end
      start = 2'b00;
      rst   = 1'b1;

      // Continuous: D0=4, D1=15
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("cont_q0",   32'(Qount[3:0]), 32'(exp_c0[k]));
         chk("cont_s0",   32'(strb[0]),    32'(exp_s0[k]));
         chk("cont_q1",   32'(Qount[7:4]), 32'(k));
         chk("cont_busy", 32'(busy),       32'd3);
      end
      for (int n = 13; n <= 33; n++) begin
         tick();
         chk("cont_s1", 32'(strb[1]),    32'((n == 17) || (n == 33)));
         chk("cont_q0", 32'(Qount[3:0]), 32'((n - 1) % 5));
         chk("cont_s0", 32'(strb[0]),    32'(((n - 1) % 5) == 0));
      end

      // Pause at count 2, reload 3 -> 6 while paused
      rst   = 1'b0;
      div_i = {4'd15, 4'd3};
      tick();
      rst = 1'b1;
      tick();
      tick();
      tick();
      chk("pause_pre", 32'(Qount[3:0]), 32'd2);
      en    = 1'b0;
      div_i = {4'd15, 4'd6};
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("pause_hold", 32'(Qount[3:0]), 32'd2);
         chk("pause_strb", 32'(strb[0]),    32'd0);
         chk("pause_busy", 32'(busy[0]),    32'd1);
      end
      en = 1'b1;
      tick();
      chk("reload_q3", 32'(Qount[3:0]), 32'd3);
      tick();
      chk("reload_wrap_q", 32'(Qount[3:0]), 32'd0);
      chk("reload_wrap_s", 32'(strb[0]),    32'd1);
      for (int v = 1; v <= 6; v++) begin
         tick();
         chk("reload_q", 32'(Qount[3:0]), 32'(v));
         chk("reload_s", 32'(strb[0]),    32'd0);
      end
      tick();
      chk("reload_wrap2_q", 32'(Qount[3:0]), 32'd0);
      chk("reload_wrap2_s", 32'(strb[0]),    32'd1);

      // One-shot on channel 1, D1=2, second start while busy
      mode  = 2'b10;
      div_i = {4'd2, 4'd4};
      rst   = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("os_idle_busy", 32'(busy[1]),    32'd0);
      chk("os_idle_q",    32'(Qount[7:4]), 32'd0);
      start = 2'b10;
      tick();
      start = 2'b00;
      chk("os_k_busy", 32'(busy[1]),    32'd1);
      chk("os_k_q",    32'(Qount[7:4]), 32'd0);
      chk("os_k_strb", 32'(strb[1]),    32'd0);
      tick();
      chk("os_k1_q",    32'(Qount[7:4]), 32'd1);
      chk("os_k1_busy", 32'(busy[1]),    32'd1);
      start = 2'b10;
      tick();
      start = 2'b00;
      chk("os_k2_q",    32'(Qount[7:4]), 32'd2);
      chk("os_k2_busy", 32'(busy[1]),    32'd1);
      chk("os_k2_strb", 32'(strb[1]),    32'd0);
      tick();
      chk("os_k3_q",    32'(Qount[7:4]), 32'd0);
      chk("os_k3_strb", 32'(strb[1]),    32'd1);
      chk("os_k3_busy", 32'(busy[1]),    32'd0);
      tick();
      chk("os_k4_q",    32'(Qount[7:4]), 32'd0);
      chk("os_k4_strb", 32'(strb[1]),    32'd0);
      chk("os_k4_busy", 32'(busy[1]),    32'd0);

      // D=0: strobe on every tick
      mode  = 2'b00;
      div_i = {4'd2, 4'd0};
      rst   = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("d0_entry_s", 32'(strb[0]), 32'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("d0_s", 32'(strb[0]),    32'd1);
         chk("d0_q", 32'(Qount[3:0]), 32'd0);
      end

      // Reset mid-period at count 3
      div_i = {4'd2, 4'd5};
      rst   = 1'b0;
      tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk("mid_pre_q", 32'(Qount[3:0]), 32'd3);
      rst = 1'b0;
      tick();
      chk("mid_rst_q",    32'(Qount), 32'd0);
      chk("mid_rst_strb", 32'(strb),  32'd0);
      chk("mid_rst_busy", 32'(busy),  32'd0);
      rst = 1'b1;

`ifdef PRESC_CASCADE_EN
      // Cascade: D0=1, D1=2 -> strb[1] period 6, one cycle after strb[0]
      div_i = {4'd2, 4'd1};
      rst   = 1'b0;
      tick();
      rst = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         tick();
         chk("casc_s1", 32'(strb[1]), 32'((n == 8) || (n == 14)));
         chk("casc_s0", 32'(strb[0]), 32'((n >= 3) && ((n % 2) == 1)));
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/presc_multi.md
# presc_multi

Parametrised multi-channel prescaler: next generation of the single 4-bit `presc` counter/strobe block. Each of `CH` independent channels counts enabled clock ticks up to a programmable terminal value and emits a one-cycle strobe. Each channel runs continuous or one-shot. The block sits between the system clock and any logic needing slow periodic enables (blinkers, sampling ticks, debounce timing).

## Interface
- `WIDTH`, default 4: counter and divide-value width per channel.
- `CH`, default 2: number of channels; channel i uses bit slice `[i*WIDTH +: WIDTH]` of packed buses.

- `clk`, input, 1: single system clock; all logic on posedge.
- `rst`, input, 1: one clock; reset is synchronous and active-low (`rst`=0 at a posedge resets).
- `en`, input, 1: global tick enable; when 0 all channels hold state.
- `div_i`, input, CH*WIDTH: per-channel terminal value D; period = D+1 ticks.
- `mode`, input, CH: per channel, 0 = continuous, 1 = one-shot.
- `start`, input, CH: per-channel one-shot trigger, sampled at posedge.
- `Qount`, output, CH*WIDTH: current count per channel, registered.
- `strb`, output, CH: one-cycle terminal strobe per channel, registered.
- `busy`, output, CH: channel in RUN state, registered.

## Operation
- Per-channel registers: `cnt`, `div_q` (latched D), state {IDLE, RUN}, `strb`.
- Reset (`rst`=0): `cnt`=0, `strb`=0, state=IDLE, `busy`=0, `div_q`<=`div_i` slice. Reset overrides every other input.
- tick_i = `en` & (state=RUN); see Configuration for the cascade term.
- IDLE -> RUN: mode=0 and `en`=1; or mode=1 and `start[i]`=1 and `en`=1. The entry edge does not count; `cnt` stays 0.
- RUN, tick, `cnt`<`div_q`: `cnt`<=`cnt`+1, `strb`<=0.
- RUN, tick, `cnt`==`div_q`: `cnt`<=0, `strb`<=1, `div_q`<=`div_i` slice. mode=1: state<=IDLE. mode=0: stay RUN.
- No tick: `cnt` and `div_q` hold; `strb`<=0.
- `en`=0 in RUN: pause, no state change, no clear.
- mode=0 channel in RUN with `en`=0 stays RUN. `busy` stays 1.
- D=0: strobe on every tick; one-shot completes after one tick.
- `div_i` changes take effect only at wrap or reset. A mid-period change never truncates or stretches the current period.
- `start` while one-shot channel is RUN: ignored. `start` on a mode=0 channel: ignored.
- `mode` change mid-period: sampled at the terminal edge only.
- Arithmetic: unsigned `WIDTH`-bit. `cnt` never exceeds `div_q`, so no overflow path exists. D=2^WIDTH-1 gives the maximum period 2^WIDTH.

## Timing
- All outputs are registers; no combinational input-to-output path.
- Continuous, `en`=1 held: `Qount` sequence 0,1,…,D,0. `strb`=1 in the cycle where `Qount` returns to 0. Strobe period exactly D+1 cycles.
- After `rst` rises with `en`=1, mode=0: edge 1 is IDLE->RUN. The first `strb` is visible after edge D+2.
- One-shot: `start` at edge k (`en`=1) gives `busy`=1 from k. `strb`=1 and `busy`=0 after edge k+D+1.
- `strb` is never high for 2 consecutive cycles when D≥1 and no cascade applies.

## Configuration
- `PRESC_CASCADE_EN` defined: for i≥1, tick_i = `en` & RUN & `strb[i-1]`, so channel i divides channel i-1's strobe rate. Channel i's strobe trails channel i-1's by one cycle. Total period = product of (D_i+1). Channel 0 is unchanged.
- Undefined: every channel ticks on `clk` independently, as above.

## Test plan
- Reset: hold `rst`=0 for 5 cycles with `en`=1 and random `start` -> `Qount`=0, `strb`=0, `busy`=0 throughout.
- Continuous: WIDTH=4, D0=4, mode=0, `en`=1 -> `Qount[3:0]` sequence 0,0,1,2,3,4,0,… and `strb[0]` period 5. With D1=15, `strb[1]` period 16.
- Pause and reload: D0=3; drop `en` for 3 cycles at `Qount`=2 -> count holds at 2. While paused, change D0 to 6 -> current period ends at 3, next period ends at 6.
- One-shot: mode[1]=1, D1=2, `start[1]` pulse -> `busy[1]` high for 3 cycles, exactly one `strb[1]`, then IDLE with `Qount`=0. A second `start` while busy is ignored.
- Edge cases: D=0 gives `strb`=1 every cycle. Assert `rst`=0 mid-period at `Qount`=3 -> next cycle `Qount`=0, `strb`=0, `busy`=0.
- With `PRESC_CASCADE_EN`: D0=1, D1=2 -> `strb[1]` period 6 cycles, each pulse one cycle after a `strb[0]` pulse.
